// File: rtl/tile_grid_renderer_if.sv
// Bundle of the pixel, tile-write, clear and colour signals of tile_grid_renderer.
//   master: drives pixel coordinates, write requests, clear and cursor; sees
//           wr_ready/wr_err and the rendered colour.
//   slave : the renderer side (inverse directions).
interface tile_grid_renderer_if;
    logic [9:0] px;
    logic [9:0] py;
    logic       pix_valid;
    logic       wr_en;
    logic [2:0] wr_x;
    logic [2:0] wr_y;
    logic [5:0] wr_val;
    logic       wr_ready;
    logic       wr_err;
    logic       clr_req;
    logic [2:0] cur_x;
    logic [2:0] cur_y;
    logic [9:0] oRed;
    logic [9:0] oGreen;
    logic [9:0] oBlue;
    logic       o_valid;
    logic       o_hit;

    modport master (
        output px, py, pix_valid, wr_en, wr_x, wr_y, wr_val, clr_req, cur_x, cur_y,
        input  wr_ready, wr_err, oRed, oGreen, oBlue, o_valid, o_hit
    );

    modport slave (
        input  px, py, pix_valid, wr_en, wr_x, wr_y, wr_val, clr_req, cur_x, cur_y,
        output wr_ready, wr_err, oRed, oGreen, oBlue, o_valid, o_hit
    );
endinterface

// File: rtl/tile_grid_renderer.sv
// Tile grid renderer: a GRID_W x GRID_H grid of 6-bit cells drawn as square
// tiles, with a cursor tile highlighted by a white border.
//   iCLK      : clock, all state on the rising edge
//   iRST      : asynchronous active-high reset
//   bus.slave : px/py/pix_valid pixel stream in, oRed/oGreen/oBlue/o_valid/o_hit
//               out 2 cycles later; wr_* tile writes with wr_ready/wr_err;
//               clr_req clears the grid one cell per cycle; cur_x/cur_y cursor.
module tile_grid_renderer #(
    parameter int unsigned GRID_W    = 4,
    parameter int unsigned GRID_H    = 4,
    parameter int unsigned BLOCK_DIM = 100,
    parameter int unsigned MARGIN    = 10,
    parameter int unsigned X_OFF     = 100,
    parameter int unsigned Y_OFF     = 20,
    parameter int unsigned BORDER    = 3
) (
    input logic                 iCLK,
    input logic                 iRST,
    tile_grid_renderer_if.slave bus
);
    localparam int unsigned NCells = GRID_W * GRID_H;
    localparam int unsigned IdxW   = (NCells > 1) ? $clog2(NCells) : 1;
    localparam int unsigned Pitch  = BLOCK_DIM + MARGIN;

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    logic [5:0]      cells_q [NCells];
    state_t          state_q;
    logic [IdxW-1:0] clr_idx_q;
    logic            wr_ready_q;
    logic            wr_err_q;

    // Stage-1 tile decode: one comparator pair per column and per row.
    logic [31:0] lo_x, lo_y;
    logic        col_hit, row_hit;
    logic [2:0]  col, row;
    logic [9:0]  lx, ly;

    always_comb begin
        lo_x    = '0;
        lo_y    = '0;
        col_hit = 1'b0;
        row_hit = 1'b0;
        col     = '0;
        row     = '0;
        lx      = '0;
        ly      = '0;
        for (int unsigned c = 0; c < GRID_W; c++) begin
            lo_x = X_OFF + MARGIN + Pitch * c;
            if ({22'd0, bus.px} >= lo_x && {22'd0, bus.px} < lo_x + BLOCK_DIM) begin
                col_hit = 1'b1;
                col     = 3'(c);
                lx      = bus.px - 10'(lo_x);
            end
        end
        for (int unsigned r = 0; r < GRID_H; r++) begin
            lo_y = Y_OFF + MARGIN + Pitch * r;
            if ({22'd0, bus.py} >= lo_y && {22'd0, bus.py} < lo_y + BLOCK_DIM) begin
                row_hit = 1'b1;
                row     = 3'(r);
                ly      = bus.py - 10'(lo_y);
            end
        end
    end

    logic       s1_valid_q, s1_hit_q;
    logic [2:0] s1_col_q, s1_row_q;
    logic [9:0] s1_lx_q, s1_ly_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_lx_q    <= '0;
            s1_ly_q    <= '0;
        end else begin
            s1_valid_q <= bus.pix_valid;
            s1_hit_q   <= col_hit & row_hit;
            s1_col_q   <= col;
            s1_row_q   <= row;
            s1_lx_q    <= lx;
            s1_ly_q    <= ly;
        end
    end

    function automatic logic [29:0] palette(input logic [5:0] v);
        case (v)
            6'd0:    palette = {10'h0C0, 10'h0C0, 10'h0C0};
            6'd1:    palette = {10'h000, 10'h3FF, 10'h3FF};
            6'd2:    palette = {10'h3FF, 10'h000, 10'h3FF};
            6'd3:    palette = {10'h3FF, 10'h3FF, 10'h000};
            6'd4:    palette = {10'h000, 10'h000, 10'h3FF};
            default: palette = {10'h3FF, 10'h000, 10'h000};
        endcase
    endfunction

    // Stage 2: cell lookup reads the live registers, so a write lands one
    // cycle after it is accepted.
    logic [IdxW-1:0] rd_idx;
    logic            cur_in_range, on_cursor, on_border;
    logic [29:0]     rgb_d;

    always_comb begin
        rd_idx       = IdxW'(32'(s1_row_q) * GRID_W + 32'(s1_col_q));
        cur_in_range = ({29'd0, bus.cur_x} < GRID_W) && ({29'd0, bus.cur_y} < GRID_H);
        on_cursor    = cur_in_range && s1_col_q == bus.cur_x && s1_row_q == bus.cur_y;
        on_border    = ({22'd0, s1_lx_q} < BORDER) || ({22'd0, s1_lx_q} >= BLOCK_DIM - BORDER) ||
                       ({22'd0, s1_ly_q} < BORDER) || ({22'd0, s1_ly_q} >= BLOCK_DIM - BORDER);
        rgb_d        = '0;
        if (s1_valid_q && s1_hit_q) begin
            if (on_cursor && on_border) rgb_d = {30{1'b1}};
            else                        rgb_d = palette(cells_q[rd_idx]);
        end
    end

    logic [9:0] red_q, green_q, blue_q;
    logic       o_valid_q, o_hit_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            o_valid_q <= 1'b0;
            o_hit_q   <= 1'b0;
        end else begin
            {red_q, green_q, blue_q} <= rgb_d;
            o_valid_q <= s1_valid_q;
            o_hit_q   <= s1_valid_q & s1_hit_q;
        end
    end

    // Cell storage, write port and clear sequencer.
    logic            wr_in_range;
    logic [IdxW-1:0] wr_idx;

    always_comb begin
        wr_in_range = ({29'd0, bus.wr_x} < GRID_W) && ({29'd0, bus.wr_y} < GRID_H);
        wr_idx      = IdxW'(32'(bus.wr_y) * GRID_W + 32'(bus.wr_x));
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int unsigned i = 0; i < NCells; i++) cells_q[i] <= '0;
            state_q    <= IDLE;
            clr_idx_q  <= '0;
            wr_ready_q <= 1'b1;
            wr_err_q   <= 1'b0;
        end else begin
            wr_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // clr_req wins over a simultaneous write.
                    if (bus.clr_req) begin
                        state_q    <= CLEAR;
                        clr_idx_q  <= '0;
                        wr_ready_q <= 1'b0;
                    end else if (bus.wr_en && wr_ready_q) begin
                        if (wr_in_range) cells_q[wr_idx] <= bus.wr_val;
                        else             wr_err_q        <= 1'b1;
                    end
                end
                CLEAR: begin
                    cells_q[clr_idx_q] <= '0;
                    if (clr_idx_q == IdxW'(NCells - 1)) begin
                        state_q    <= IDLE;
                        wr_ready_q <= 1'b1;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oRed     = red_q;
    assign bus.oGreen   = green_q;
    assign bus.oBlue    = blue_q;
    assign bus.o_valid  = o_valid_q;
    assign bus.o_hit    = o_hit_q;
    assign bus.wr_ready = wr_ready_q;
    assign bus.wr_err   = wr_err_q;
endmodule

// File: tb/tb_tile_grid_renderer.sv
// Directed bench for tile_grid_renderer (default 4x4 grid). Pixels are driven
// on the falling edge; the expected colour is queued with its due cycle and
// compared on the falling edge two rising edges later.
module tb_tile_grid_renderer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tile_grid_renderer_if bus ();

    tile_grid_renderer dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    localparam logic [29:0] Black  = 30'd0;
    localparam logic [29:0] White  = {10'h3FF, 10'h3FF, 10'h3FF};
    localparam logic [29:0] Grey   = {10'h0C0, 10'h0C0, 10'h0C0};
    localparam logic [29:0] Yellow = {10'h3FF, 10'h3FF, 10'h000};

    typedef struct {
        string       tag;
        logic [29:0] rgb;
        logic        hit;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    int   model[16];
    int   n;

    always @(posedge clk) cyc++;

    function automatic logic [29:0] pal(input int v);
        case (v)
            0:       return Grey;
            1:       return {10'h000, 10'h3FF, 10'h3FF};
            2:       return {10'h3FF, 10'h000, 10'h3FF};
            3:       return Yellow;
            4:       return {10'h000, 10'h000, 10'h3FF};
            default: return {10'h3FF, 10'h000, 10'h000};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, " valid"}, 32'(bus.o_valid), 32'd1);
                chk({mon_e.tag, " rgb"}, {2'b0, bus.oRed, bus.oGreen, bus.oBlue},
                    {2'b0, mon_e.rgb});
                chk({mon_e.tag, " hit"}, 32'(bus.o_hit), 32'(mon_e.hit));
            end else begin
                chk("idle valid", 32'(bus.o_valid), 32'd0);
                chk("idle rgb", {2'b0, bus.oRed, bus.oGreen, bus.oBlue}, 32'd0);
            end
        end
    end

    // Must be called on a falling edge; returns one falling edge later.
    task automatic pix(input int x, input int y, input logic [29:0] rgb, input logic hit,
                       input string tag);
        exp_t e;
        e.tag = tag;
        e.rgb = rgb;
        e.hit = hit;
        e.due = cyc + 2;
        bus.px        = 10'(x);
        bus.py        = 10'(y);
        bus.pix_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        bus.pix_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic wr(input int x, input int y, input int v);
        bus.wr_en  = 1'b1;
        bus.wr_x   = 3'(x);
        bus.wr_y   = 3'(y);
        bus.wr_val = 6'(v);
        if (x < 4 && y < 4) model[y * 4 + x] = v & 63;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Render every tile centre back to back and compare against the model.
    task automatic rd_all(input string tag);
        for (int i = 0; i < 16; i++)
            pix(160 + 110 * (i % 4), 80 + 110 * (i / 4), pal(model[i]), 1'b1, tag);
        drain();
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 16; i++) wr(i % 4, i / 4, v);
    endtask

    initial begin
        rst           = 1'b1;
        bus.px        = '0;
        bus.py        = '0;
        bus.pix_valid = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_x      = '0;
        bus.wr_y      = '0;
        bus.wr_val    = '0;
        bus.clr_req   = 1'b0;
        bus.cur_x     = 3'd7;
        bus.cur_y     = 3'd7;
        for (int i = 0; i < 16; i++) model[i] = 0;
        repeat (2) @(negedge clk);
        chk("reset rgb", {2'b0, bus.oRed, bus.oGreen, bus.oBlue}, 32'd0);
        chk("reset valid", 32'(bus.o_valid), 32'd0);
        chk("reset hit", 32'(bus.o_hit), 32'd0);
        chk("reset wr_err", 32'(bus.wr_err), 32'd0);
        chk("reset wr_ready", 32'(bus.wr_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        pix(150, 60, Grey, 1'b1, "first pixel");
        drain();

        wr(1, 0, 3);
        chk("good write err", 32'(bus.wr_err), 32'd0);
        pix(220, 30, Yellow, 1'b1, "col1 first px");
        pix(215, 30, Black, 1'b0, "col gap");
        pix(319, 30, Yellow, 1'b1, "col1 last px");
        pix(320, 30, Black, 1'b0, "col1 end");
        pix(150, 29, Black, 1'b0, "above row0");
        pix(150, 129, Grey, 1'b1, "row0 last px");
        pix(150, 130, Black, 1'b0, "row gap");
        pix(109, 60, Black, 1'b0, "left margin");
        drain();

        bus.cur_x = 3'd0;
        bus.cur_y = 3'd0;
        pix(111, 80, White, 1'b1, "cursor left");
        pix(113, 80, Grey, 1'b1, "cursor inner x");
        pix(207, 80, White, 1'b1, "cursor right");
        pix(206, 80, Grey, 1'b1, "cursor inner xr");
        pix(150, 32, White, 1'b1, "cursor top");
        pix(150, 127, White, 1'b1, "cursor bottom");
        pix(150, 126, Grey, 1'b1, "cursor inner y");
        pix(221, 31, Yellow, 1'b1, "non-cursor edge");
        bus.cur_x = 3'd4;
        pix(111, 80, Grey, 1'b1, "cursor oor");
        bus.cur_x = 3'd7;
        drain();

        wr(5, 0, 9);
        chk("bad x err pulse", 32'(bus.wr_err), 32'd1);
        @(negedge clk);
        chk("bad x err drop", 32'(bus.wr_err), 32'd0);
        wr(0, 5, 9);
        chk("bad y err pulse", 32'(bus.wr_err), 32'd1);
        @(negedge clk);
        rd_all("after bad writes");

        for (int i = 0; i < 16; i++) wr(i % 4, i / 4, (i < 8) ? i : 63 - i);
        rd_all("palette");

        fill(7);
        rd_all("sevens");

        // Clear: a write and a repeated clr_req are presented mid-clear.
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        n = 0;
        while (bus.wr_ready === 1'b0 && n < 100) begin
            n++;
            if (n == 3) begin
                bus.wr_en   = 1'b1;
                bus.wr_x    = 3'd0;
                bus.wr_y    = 3'd0;
                bus.wr_val  = 6'd5;
                bus.clr_req = 1'b1;
            end else begin
                bus.wr_en   = 1'b0;
                bus.clr_req = 1'b0;
            end
            @(negedge clk);
            chk("no err in clear", 32'(bus.wr_err), 32'd0);
        end
        bus.wr_en   = 1'b0;
        bus.clr_req = 1'b0;
        chk("clear busy cycles", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) model[i] = 0;
        rd_all("after clear");

        // Reset five cycles into a clear while pixels are streaming.
        fill(7);
        mon_en        = 1'b0;
        bus.px        = 10'd150;
        bus.py        = 10'd60;
        bus.pix_valid = 1'b1;
        bus.clr_req   = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy before abort", 32'(bus.wr_ready), 32'd0);
        chk("valid before abort", 32'(bus.o_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort rgb", {2'b0, bus.oRed, bus.oGreen, bus.oBlue}, 32'd0);
        chk("abort valid", 32'(bus.o_valid), 32'd0);
        chk("abort hit", 32'(bus.o_hit), 32'd0);
        chk("abort wr_ready", 32'(bus.wr_ready), 32'd1);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 0;
        @(negedge clk);
        mon_en = 1'b1;
        chk("idle after abort", 32'(bus.wr_ready), 32'd1);
        rd_all("after abort");
        wr(2, 1, 2);
        chk("write after abort", 32'(bus.wr_err), 32'd0);
        rd_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
